// File: rtl/disp_secuenciador_if.sv
// rtl/disp_secuenciador_if.sv - recipe request / ingredient drive bundle for the dispenser sequencer
interface disp_secuenciador_if #(
   parameter int NUM_ING = 3,
   parameter int CNT_W   = 3
);
   localparam int CANAL_W = (NUM_ING > 1) ? $clog2(NUM_ING) : 1;

   logic                     start;
   logic [NUM_ING*CNT_W-1:0] dosis;
   logic                     pausa;
   logic                     abortar;
   logic [NUM_ING-1:0]       led;
   logic [CANAL_W-1:0]       canal;
   logic [CNT_W-1:0]         counter;
   logic                     busy;
   logic                     done;
   logic                     abortado;

   modport master (
      output start, dosis, pausa, abortar,
      input  led, canal, counter, busy, done, abortado
   );

   modport slave (
      input  start, dosis, pausa, abortar,
      output led, canal, counter, busy, done, abortado
   );
endinterface

// File: rtl/disp_secuenciador.sv
// rtl/disp_secuenciador.sv - multi-ingredient dispenser sequencer with pause and abort
module disp_secuenciador #(
   parameter int NUM_ING = 3,
   parameter int CNT_W   = 3
) (
   input logic                clk,
   input logic                rst,
   disp_secuenciador_if.slave bus
);
   localparam int CANAL_W = (NUM_ING > 1) ? $clog2(NUM_ING) : 1;
   localparam logic [NUM_ING-1:0] LED_ONE   = NUM_ING'(1);
   localparam logic [CANAL_W-1:0] LAST_CH   = CANAL_W'(NUM_ING - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DISP = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] dose_q [NUM_ING];
   logic [CNT_W-1:0] cur_dose;

   assign cur_dose = dose_q[bus.canal];

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         bus.led      <= '0;
         bus.canal    <= '0;
         bus.counter  <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.abortado <= 1'b0;
         for (int i = 0; i < NUM_ING; i++) dose_q[i] <= '0;
      end else begin
         bus.done     <= 1'b0;
         bus.abortado <= 1'b0;
         case (state)
            IDLE: begin
               bus.led <= '0;
               if (bus.start && !bus.abortar) begin
                  for (int i = 0; i < NUM_ING; i++) dose_q[i] <= bus.dosis[i*CNT_W +: CNT_W];
                  bus.canal   <= '0;
                  bus.counter <= '0;
                  bus.busy    <= 1'b1;
                  state       <= DISP;
               end
            end
            DISP: begin
               if (bus.abortar) begin
                  bus.led      <= '0;
                  bus.counter  <= '0;
                  bus.canal    <= '0;
                  bus.busy     <= 1'b0;
                  bus.abortado <= 1'b1;
                  state        <= IDLE;
               end else if (bus.pausa) begin
                  bus.led <= '0;
               end else if (bus.counter < cur_dose) begin
                  bus.led     <= LED_ONE << bus.canal;
                  bus.counter <= bus.counter + CNT_ONE;
               end else begin
                  // gap tick: every channel ends with one led-low edge, even at dose 0
                  bus.led     <= '0;
                  bus.counter <= '0;
                  if (bus.canal == LAST_CH) begin
                     bus.done <= 1'b1;
                     state    <= DONE;
                  end else begin
                     bus.canal <= bus.canal + CANAL_W'(1);
                  end
               end
            end
            DONE: begin
               bus.led     <= '0;
               bus.canal   <= '0;
               bus.counter <= '0;
               bus.busy    <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               bus.led  <= '0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_disp_secuenciador.sv
// tb/tb_disp_secuenciador.sv - directed bench for the dispenser sequencer
module tb_disp_secuenciador;
   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   disp_secuenciador_if #(.NUM_ING(3), .CNT_W(3)) bus ();

   disp_secuenciador #(.NUM_ING(3), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      bus.start = 0; bus.pausa = 0; bus.abortar = 0;
      while (bus.busy === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL drain_timeout: busy=%b after %0d cycles, expected 0", bus.busy, n);
      end
      tick();
   endtask

   task automatic test_reset();
      rst = 1;
      tick();
      checks++;
      if ({bus.led, bus.canal, bus.counter, bus.busy, bus.done, bus.abortado} !== 11'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected all 0",
                  {bus.led, bus.canal, bus.counter, bus.busy, bus.done, bus.abortado});
      end
      rst = 0;
      tick();
   endtask

   task automatic test_basic();
      logic [2:0] exp_led [7] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000};
      logic [2:0] exp_cnt [7] = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0};
      logic [1:0] exp_can [7] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
      logic       exp_don [7] = '{0, 0, 0, 0, 0, 1, 0};
      logic       exp_bsy [7] = '{1, 1, 1, 1, 1, 1, 0};
      bus.dosis = {3'd1, 3'd0, 3'd2};
      bus.start = 1;
      tick();
      bus.start = 0;
      checks++;
      if (bus.busy !== 1'b1 || bus.led !== 3'b000) begin
         errors++;
         $display("FAIL basic_accept: busy=%b led=%b expected busy=1 led=000", bus.busy, bus.led);
      end
      for (int e = 0; e < 7; e++) begin
         tick();
         checks++;
         if (bus.led !== exp_led[e] || bus.counter !== exp_cnt[e] || bus.canal !== exp_can[e] ||
             bus.done !== exp_don[e] || bus.busy !== exp_bsy[e]) begin
            errors++;
            $display("FAIL basic_E%0d: led=%b cnt=%0d canal=%0d done=%b busy=%b expected led=%b cnt=%0d canal=%0d done=%b busy=%b",
                     e + 1, bus.led, bus.counter, bus.canal, bus.done, bus.busy,
                     exp_led[e], exp_cnt[e], exp_can[e], exp_don[e], exp_bsy[e]);
         end
      end
   endtask

   task automatic test_pause();
      int done_at = -1;
      bus.dosis = {3'd1, 3'd0, 3'd2};
      bus.start = 1;
      tick();
      bus.start = 0;
      tick();
      bus.pausa = 1;
      for (int p = 0; p < 3; p++) begin
         tick();
         checks++;
         if (bus.led !== 3'b000 || bus.counter !== 3'd1 || bus.canal !== 2'd0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL pause_hold_%0d: led=%b cnt=%0d canal=%0d busy=%b expected led=000 cnt=1 canal=0 busy=1",
                     p, bus.led, bus.counter, bus.canal, bus.busy);
         end
      end
      bus.pausa = 0;
      tick();
      checks++;
      if (bus.led !== 3'b001 || bus.counter !== 3'd2) begin
         errors++;
         $display("FAIL pause_resume: led=%b cnt=%0d expected led=001 cnt=2", bus.led, bus.counter);
      end
      for (int e = 6; e < 14 && done_at < 0; e++) begin
         tick();
         if (bus.done === 1'b1) done_at = e;
      end
      checks++;
      if (done_at != 9) begin
         errors++;
         $display("FAIL pause_done_edge: done at E%0d expected E9", done_at);
      end
      drain();
   endtask

   task automatic test_abort();
      bus.dosis = {3'd1, 3'd0, 3'd2};
      bus.start = 1;
      tick();
      bus.start = 0;
      tick();
      bus.abortar = 1;
      tick();
      bus.abortar = 0;
      checks++;
      if (bus.abortado !== 1'b1 || bus.busy !== 1'b0 || bus.led !== 3'b000 ||
          bus.counter !== 3'd0 || bus.canal !== 2'd0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL abort_E2: abortado=%b busy=%b led=%b cnt=%0d canal=%0d done=%b expected 1 0 000 0 0 0",
                  bus.abortado, bus.busy, bus.led, bus.counter, bus.canal, bus.done);
      end
      tick();
      checks++;
      if (bus.abortado !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_E3: abortado=%b done=%b busy=%b expected 0 0 0", bus.abortado, bus.done, bus.busy);
      end
      bus.start = 1;
      tick();
      bus.start = 0;
      bus.dosis = 9'd0;
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_restart: busy=%b expected 1", bus.busy);
      end
      tick();
      checks++;
      if (bus.led !== 3'b001) begin
         errors++;
         $display("FAIL abort_dosis_latched: led=%b expected 001", bus.led);
      end
      drain();
   endtask

   task automatic test_zero();
      logic [2:0] led_or = 3'b000;
      logic       exp_don [3] = '{0, 0, 1};
      bus.dosis = 9'd0;
      bus.start = 1;
      tick();
      bus.start = 0;
      for (int e = 0; e < 3; e++) begin
         tick();
         led_or |= bus.led;
         checks++;
         if (bus.done !== exp_don[e]) begin
            errors++;
            $display("FAIL zero_done_E%0d: done=%b expected %b", e + 1, bus.done, exp_don[e]);
         end
      end
      checks++;
      if (led_or !== 3'b000) begin
         errors++;
         $display("FAIL zero_led: led ever high=%b expected 000", led_or);
      end
      bus.abortar = 1;
      tick();
      bus.abortar = 0;
      checks++;
      if (bus.abortado !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL zero_abort_in_done: abortado=%b busy=%b done=%b expected 0 0 0",
                  bus.abortado, bus.busy, bus.done);
      end
      tick();
   endtask

   task automatic test_max_dose();
      bus.dosis = {3'd0, 3'd0, 3'd7};
      bus.start = 1;
      tick();
      bus.start = 0;
      for (int e = 1; e <= 7; e++) begin
         bus.start = (e == 3);
         tick();
         checks++;
         if (bus.led !== 3'b001 || bus.counter !== 3'(e)) begin
            errors++;
            $display("FAIL max_E%0d: led=%b cnt=%0d expected led=001 cnt=%0d", e, bus.led, bus.counter, e);
         end
      end
      bus.start = 0;
      tick();
      checks++;
      if (bus.led !== 3'b000 || bus.counter !== 3'd0 || bus.canal !== 2'd1) begin
         errors++;
         $display("FAIL max_gap: led=%b cnt=%0d canal=%0d expected 000 0 1", bus.led, bus.counter, bus.canal);
      end
      tick();
      tick();
      checks++;
      if (bus.done !== 1'b1) begin
         errors++;
         $display("FAIL max_done_E10: done=%b expected 1", bus.done);
      end
      bus.start = 1;
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL max_start_in_done: busy=%b done=%b expected 0 0", bus.busy, bus.done);
      end
      tick();
      bus.start = 0;
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL max_start_after_done: busy=%b expected 1", bus.busy);
      end
      bus.abortar = 1;
      tick();
      bus.abortar = 0;
      tick();
   endtask

   task automatic test_rst_mid();
      bus.dosis = {3'd1, 3'd0, 3'd2};
      bus.start = 1;
      tick();
      bus.start = 0;
      tick();
      tick();
      rst = 1;
      tick();
      rst = 0;
      checks++;
      if ({bus.led, bus.canal, bus.counter, bus.busy, bus.done, bus.abortado} !== 11'b0) begin
         errors++;
         $display("FAIL rst_mid: got %b expected all 0",
                  {bus.led, bus.canal, bus.counter, bus.busy, bus.done, bus.abortado});
      end
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.led !== 3'b000) begin
         errors++;
         $display("FAIL rst_mid_idle: busy=%b led=%b expected 0 000", bus.busy, bus.led);
      end
      bus.start = 1;
      bus.abortar = 1;
      tick();
      bus.start = 0;
      bus.abortar = 0;
      checks++;
      if (bus.busy !== 1'b0 || bus.abortado !== 1'b0) begin
         errors++;
         $display("FAIL start_abort_same_edge: busy=%b abortado=%b expected 0 0", bus.busy, bus.abortado);
      end
      tick();
   endtask

   initial begin
      rst = 1;
      bus.start = 0;
      bus.pausa = 0;
      bus.abortar = 0;
      bus.dosis = '0;
      tick();
      test_reset();
      test_basic();
      test_pause();
      test_abort();
      test_zero();
      test_max_dose();
      test_rst_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
